stream_sum_accum: RTL and testbench



---
 rtl/stream_sum_pkg.sv | 25 ++
 rtl/lane_add_tree.sv | 38 +++
 rtl/stream_sum_accum.sv | 131 +++++++++++++
 tb/tb_stream_sum_accum.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_sum_pkg.sv
// Shared types and width helpers for the streaming frame adder.
// Used by the RTL and by the bench so both agree on the result width.
package stream_sum_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // NUM_OPS operands of DATA_W bits can grow by at most clog2(NUM_OPS) bits.
  function automatic int sum_width(input int data_w, input int num_ops);
    return data_w + clog2(num_ops);
  endfunction

endpackage

// File: rtl/lane_add_tree.sv
// Combinational balanced binary adder tree over LANES operands, zero- or sign-extended to OUT_W.
// No latency, no flow control; LANES must be a power of two.
module lane_add_tree
  import stream_sum_pkg::*;
#(
  parameter int LANES  = 8,
  parameter int DATA_W = 4,
  parameter int OUT_W  = 11,
  parameter int SIGNED = 0
) (
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic [OUT_W-1:0]        sum
);

  localparam int LEVELS = clog2(LANES);

  function automatic logic [OUT_W-1:0] extend(input logic [DATA_W-1:0] x);
    if (SIGNED != 0) begin
      return OUT_W'($signed(x));
    end
    return OUT_W'(x);
  endfunction

  // Level 0 holds the extended operands; each later level halves the node count.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    logic [OUT_W-1:0] node [LANES >> l];
    for (genvar k = 0; k < (LANES >> l); k++) begin : g_node
      if (l == 0) begin : g_leaf
        assign node[k] = extend(in_data[k*DATA_W +: DATA_W]);
      end else begin : g_add
        assign node[k] = g_lvl[l-1].node[2*k] + g_lvl[l-1].node[2*k+1];
      end
    end
  end

  assign sum = g_lvl[LEVELS].node[0];

endmodule

// File: rtl/stream_sum_accum.sv
// Streaming frame adder: LANES operands per beat, one SUM_W total per NUM_OPS-operand frame.
// Sum valid two edges after the last beat; in_ready drops from last beat until the sum is taken.
module stream_sum_accum
  import stream_sum_pkg::*;
#(
  parameter  int DATA_W  = 4,
  parameter  int LANES   = 8,
  parameter  int NUM_OPS = 128,
  parameter  int SIGNED  = 0,
  localparam int SUM_W   = sum_width(DATA_W, NUM_OPS),
  localparam int BEATS   = NUM_OPS / LANES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SUM_W-1:0]        out_sum
);

  localparam int              CNT_W     = (BEATS > 1) ? clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SUM_W-1:0]   psum_q, psum_d;
  logic               psum_v_q, psum_v_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic               out_valid_q, out_valid_d;
  logic [SUM_W-1:0]   out_sum_q, out_sum_d;
  logic               in_ready_q, in_ready_d;
  logic [SUM_W-1:0]   tree_sum;
  logic               beat_acc;

  lane_add_tree #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .OUT_W  (SUM_W),
    .SIGNED (SIGNED)
  ) u_tree (
    .in_data (in_data),
    .sum     (tree_sum)
  );

  assign beat_acc = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    psum_d      = psum_q;
    psum_v_d    = 1'b0;
    acc_d       = psum_v_q ? acc_q + psum_q : acc_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    in_ready_d  = in_ready_q;

    if (clear) begin
      state_d     = ST_ACCUM;
      cnt_d       = '0;
      acc_d       = '0;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          in_ready_d = 1'b1;
          if (beat_acc) begin
            psum_d   = tree_sum;
            psum_v_d = 1'b1;
            if (cnt_q == LAST_BEAT) begin
              cnt_d      = '0;
              state_d    = ST_FLUSH;
              in_ready_d = 1'b0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          state_d = ST_DONE;
        end
        ST_DONE: begin
          // acc already holds the final total here, so the output register can copy it.
          if (out_valid_q && out_ready) begin
            state_d     = ST_ACCUM;
            out_valid_d = 1'b0;
            acc_d       = '0;
            in_ready_d  = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            out_sum_d   = acc_q;
          end
        end
        default: begin
          state_d    = ST_ACCUM;
          in_ready_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      cnt_q       <= '0;
      psum_q      <= '0;
      psum_v_q    <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      psum_q      <= psum_d;
      psum_v_q    <= psum_v_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_stream_sum_accum.sv
// Bench for stream_sum_accum: an unsigned and a signed instance run in lockstep on shared stimulus.
module tb_stream_sum_accum;
  import stream_sum_pkg::*;

  localparam int DATA_W  = 4;
  localparam int LANES   = 8;
  localparam int NUM_OPS = 128;
  localparam int SUM_W   = sum_width(DATA_W, NUM_OPS);
  localparam int BEATS   = NUM_OPS / LANES;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    clear = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    out_ready = 1'b0;
  logic [LANES*DATA_W-1:0] in_data = '0;
  logic                    in_ready_u, in_ready_s, out_valid_u, out_valid_s;
  logic [SUM_W-1:0]        out_sum_u, out_sum_s;

  int checks = 0;
  int errors = 0;
  logic [SUM_W-1:0] exp_u[$];
  logic [SUM_W-1:0] exp_s[$];

  stream_sum_accum #(.DATA_W(DATA_W), .LANES(LANES), .NUM_OPS(NUM_OPS), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_data(in_data), .out_valid(out_valid_u), .out_ready(out_ready), .out_sum(out_sum_u));

  stream_sum_accum #(.DATA_W(DATA_W), .LANES(LANES), .NUM_OPS(NUM_OPS), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready), .out_sum(out_sum_s));

  always #5 clk = ~clk;

  // Operand patterns: 0 = six 4'hF then 4'h1, 1 = all F, 2 = all 8, 3 = all 7, else all 1.
  function automatic logic [DATA_W-1:0] op_val(input int mode, input int idx);
    case (mode)
      0:       return (idx < 6) ? 4'hF : 4'h1;
      1:       return 4'hF;
      2:       return 4'h8;
      3:       return 4'h7;
      default: return 4'h1;
    endcase
  endfunction

  function automatic logic [SUM_W-1:0] model_sum(input int mode, input bit sgn);
    int s;
    logic [DATA_W-1:0] v;
    s = 0;
    for (int i = 0; i < NUM_OPS; i++) begin
      v = op_val(mode, i);
      if (sgn && v[DATA_W-1]) s += int'(v) - (1 << DATA_W);
      else                    s += int'(v);
    end
    return SUM_W'(s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beats(input int mode, input int first, input int n, input bit bubbles,
                            output bit ok);
    bit took;
    int tries;
    ok = 1'b1;
    for (int b = first; b < first + n; b++) begin
      if (bubbles) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) step();
      end
      for (int k = 0; k < LANES; k++) in_data[k*DATA_W +: DATA_W] = op_val(mode, b*LANES + k);
      in_valid = 1'b1;
      took  = 1'b0;
      tries = 0;
      while (!took && tries < 40) begin
        took = in_ready_u;
        step();
        tries++;
      end
      if (!took) begin
        checks++;
        errors++;
        $display("FAIL beat_accept: beat %0d not accepted within 40 cycles", b);
        ok = 1'b0;
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int mode, input bit bubbles);
    bit ok;
    send_beats(mode, 0, BEATS, bubbles, ok);
    if (ok) begin
      exp_u.push_back(model_sum(mode, 1'b0));
      exp_s.push_back(model_sum(mode, 1'b1));
    end
  endtask

  task automatic wait_out(output bit ok);
    int tries;
    tries = 0;
    while (!out_valid_u && tries < 60) begin
      step();
      tries++;
    end
    ok = out_valid_u;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL out_valid_timeout: out_valid=%0b after 60 cycles, required 1", out_valid_u);
    end
  endtask

  task automatic drop_expected();
    if (exp_u.size() > 0) void'(exp_u.pop_front());
    if (exp_s.size() > 0) void'(exp_s.pop_front());
  endtask

  task automatic collect(input string name);
    bit ok;
    logic [SUM_W-1:0] eu, es;
    wait_out(ok);
    if (!ok) return;
    checks++;
    if (exp_u.size() == 0 || exp_s.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard: output with empty scoreboard, got sum %0d", name, out_sum_u);
      return;
    end
    eu = exp_u.pop_front();
    es = exp_s.pop_front();
    if (out_sum_u !== eu) begin
      errors++;
      $display("FAIL %s_sum_u: got %0d required %0d", name, out_sum_u, eu);
    end
    checks++;
    if (out_valid_s !== 1'b1 || out_sum_s !== es) begin
      errors++;
      $display("FAIL %s_sum_s: got valid %0b sum 'h%0h required valid 1 sum 'h%0h",
               name, out_valid_s, out_sum_s, es);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid_u !== 1'b0 || in_ready_u !== 1'b1) begin
      errors++;
      $display("FAIL %s_handshake: got out_valid %0b in_ready %0b required 0 1",
               name, out_valid_u, in_ready_u);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid_u !== 1'b0 || out_sum_u !== '0 || in_ready_u !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid %0b sum %0d ready %0b required 0 0 0",
               out_valid_u, out_sum_u, in_ready_u);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (in_ready_u !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready: got %0b required 0", in_ready_u);
    end
    step();
    checks++;
    if (in_ready_u !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %0b required 1", in_ready_u);
    end
  endtask

  task automatic test_frame_latency();
    send_frame(0, 1'b0);
    checks++;
    if (out_valid_u !== 1'b0) begin
      errors++;
      $display("FAIL latency_t0: out_valid %0b required 0", out_valid_u);
    end
    step();
    checks++;
    if (out_valid_u !== 1'b0 || in_ready_u !== 1'b0) begin
      errors++;
      $display("FAIL latency_t1: out_valid %0b in_ready %0b required 0 0", out_valid_u, in_ready_u);
    end
    step();
    checks++;
    if (out_valid_u !== 1'b1) begin
      errors++;
      $display("FAIL latency_t2: out_valid %0b required 1", out_valid_u);
    end
    collect("frame_equiv");
  endtask

  task automatic test_bubbles();
    send_frame(1, 1'b1);
    collect("all_f_bubbles");
  endtask

  task automatic test_signed();
    send_frame(2, 1'b0);
    collect("all_8");
    send_frame(3, 1'b1);
    collect("all_7");
  endtask

  task automatic test_backpressure();
    bit ok;
    send_frame(1, 1'b0);
    wait_out(ok);
    in_valid = 1'b1;
    for (int k = 0; k < LANES; k++) in_data[k*DATA_W +: DATA_W] = 4'hF;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid_u !== 1'b1 || in_ready_u !== 1'b0 || exp_u.size() == 0 ||
          out_sum_u !== exp_u[0]) begin
        errors++;
        $display("FAIL stall_cycle%0d: valid %0b ready %0b sum %0d required 1 0 %0d",
                 c, out_valid_u, in_ready_u, out_sum_u, model_sum(1, 1'b0));
      end
      step();
    end
    in_valid = 1'b0;
    collect("stalled");
    send_frame(4, 1'b0);
    collect("after_stall");
  endtask

  task automatic test_clear();
    bit ok;
    send_beats(1, 0, 7, 1'b0, ok);
    clear = 1'b1;
    in_valid = 1'b1;
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid_u !== 1'b0 || in_ready_u !== 1'b1) begin
      errors++;
      $display("FAIL clear_midframe: valid %0b ready %0b required 0 1", out_valid_u, in_ready_u);
    end
    send_frame(4, 1'b0);
    collect("after_clear");
    send_frame(4, 1'b0);
    wait_out(ok);
    out_ready = 1'b1;
    clear = 1'b1;
    step();
    out_ready = 1'b0;
    clear = 1'b0;
    drop_expected();
    checks++;
    if (out_valid_u !== 1'b0 || in_ready_u !== 1'b1) begin
      errors++;
      $display("FAIL clear_done: valid %0b ready %0b required 0 1", out_valid_u, in_ready_u);
    end
    send_frame(1, 1'b1);
    collect("after_clear_done");
  endtask

  task automatic test_async_reset();
    bit ok;
    send_frame(4, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid_u !== 1'b0 || out_sum_u !== '0 || in_ready_u !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_flush: valid %0b sum %0d ready %0b required 0 0 0",
               out_valid_u, out_sum_u, in_ready_u);
    end
    drop_expected();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    send_frame(1, 1'b0);
    wait_out(ok);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid_u !== 1'b0 || out_sum_u !== '0 || in_ready_u !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_done: valid %0b sum %0d ready %0b required 0 0 0",
               out_valid_u, out_sum_u, in_ready_u);
    end
    drop_expected();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    send_frame(0, 1'b1);
    collect("post_reset");
  endtask

  initial begin
    test_reset();
    test_frame_latency();
    test_bubbles();
    test_signed();
    test_backpressure();
    test_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule
